// File: rtl/tick_sched_ctrl.sv
// rtl/tick_sched_ctrl.sv - programmable tick/divided-clock controller with run/stop/one-shot sequencing
// Optional macro TICK_CNT_EN adds the saturating tick_cnt expiry counter output.
module tick_sched_ctrl #(
  parameter int WIDTH          = 32,
  parameter int DEFAULT_PERIOD = 2500,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic             cfg_oneshot,
  input  logic             start,
  input  logic             stop,
  output logic             div_clk,
  output logic             tick,
  output logic             busy,
`ifdef TICK_CNT_EN
  output logic [CNT_W-1:0] tick_cnt,
`endif
  output logic             done
);

  localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEFAULT_PERIOD);
  localparam logic [WIDTH-1:0] MIN_P = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] period_reg;
  logic             oneshot_reg;
  logic             cfg_accept;

  assign cfg_ready  = (state == IDLE) || (state == DONE);
  assign cfg_accept = cfg_valid && cfg_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      period_reg  <= DEF_P;
      oneshot_reg <= 1'b0;
      div_clk     <= 1'b0;
      tick        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef TICK_CNT_EN
      tick_cnt    <= '0;
`endif
    end else begin
      case (state)
        RUN: begin
          if (stop) begin
            // stop beats a coincident expiry: no tick, no done
            state   <= IDLE;
            busy    <= 1'b0;
            count   <= '0;
            div_clk <= 1'b0;
            tick    <= 1'b0;
          end else if (count == period_reg) begin
            count <= '0;
            tick  <= 1'b1;
`ifdef TICK_CNT_EN
            if (tick_cnt != {CNT_W{1'b1}}) tick_cnt <= tick_cnt + 1'b1;
`endif
            if (oneshot_reg) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              div_clk <= ~div_clk;
            end
          end else begin
            count <= count + 1'b1;
            tick  <= 1'b0;
          end
        end
        default: begin
          tick <= 1'b0;
          if (cfg_accept) begin
            period_reg  <= (cfg_period == '0) ? MIN_P : cfg_period;
            oneshot_reg <= cfg_oneshot;
            done        <= 1'b0;
          end
          if (start && !stop) begin
            state   <= RUN;
            busy    <= 1'b1;
            count   <= '0;
            div_clk <= 1'b0;
            done    <= 1'b0;
`ifdef TICK_CNT_EN
            tick_cnt <= '0;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_sched_ctrl.sv
// tb/tb_tick_sched_ctrl.sv - directed and randomized checks of tick_sched_ctrl against a cycle-count model
module tb_tick_sched_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_period;
  logic        cfg_oneshot;
  logic        start;
  logic        stop;
  logic        div_clk;
  logic        tick;
  logic        busy;
  logic        done;
  logic [15:0] tick_cnt;

  int total = 0;
  int bad   = 0;

  // model: elapsed cycles since the start edge drive all expectations arithmetically
  bit     m_run;
  longint m_el;
  int     m_p;
  bit     m_os;
  bit     m_done;
  bit     m_tick;
  bit     m_div;
  int     m_nt;

  always #5 clk = ~clk;

  tick_sched_ctrl #(
    .WIDTH(32),
    .DEFAULT_PERIOD(2500),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_period(cfg_period),
    .cfg_oneshot(cfg_oneshot),
    .start(start),
    .stop(stop),
    .div_clk(div_clk),
    .tick(tick),
    .busy(busy),
`ifdef TICK_CNT_EN
    .tick_cnt(tick_cnt),
`endif
    .done(done)
  );

`ifndef TICK_CNT_EN
  assign tick_cnt = 16'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_el = 0; m_p = 2500; m_os = 0;
    m_done = 0; m_tick = 0; m_div = 0; m_nt = 0;
  endtask

  task automatic model_edge(input bit cv, input int cp, input bit co, input bit st, input bit sp);
    if (!m_run) begin
      m_tick = 0;
      if (cv) begin
        m_p  = (cp == 0) ? 1 : cp;
        m_os = co;
        m_done = 0;
      end
      if (st && !sp) begin
        m_run = 1; m_el = 0; m_done = 0; m_nt = 0;
      end
    end else if (sp) begin
      m_run = 0; m_el = 0; m_tick = 0;
    end else begin
      m_el++;
      m_tick = (m_el % (m_p + 1) == 0);
      if (m_tick) begin
        if (m_nt < 65535) m_nt++;
        if (m_os) begin
          m_done = 1;
          m_run  = 0;
        end
      end
    end
    m_div = m_run && !m_os && (((m_el / (m_p + 1)) % 2) == 1);
  endtask

  task automatic check_outputs();
    chk("tick", tick, m_tick);
    chk("div_clk", div_clk, m_div);
    chk("busy", busy, m_run);
    chk("done", done, m_done);
    chk("cfg_ready", cfg_ready, !m_run);
`ifdef TICK_CNT_EN
    chk("tick_cnt", tick_cnt, m_nt);
`endif
  endtask

  task automatic step(input bit cv, input int cp, input bit co, input bit st, input bit sp);
    cfg_valid = cv; cfg_period = cp; cfg_oneshot = co; start = st; stop = sp;
    @(posedge clk);
    model_edge(cv, cp, co, st, sp);
    @(negedge clk);
    cfg_valid = 0; start = 0; stop = 0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic first_tick_latency(input string tag, input int exp_n);
    int n;
    n = 0;
    while (!tick && n < 3000) begin
      step(0, 0, 0, 0, 0);
      n++;
    end
    chk(tag, n, exp_n);
  endtask

  initial begin
    reset = 1; cfg_valid = 0; cfg_period = 0; cfg_oneshot = 0; start = 0; stop = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 0;

    // default period: first tick 2501 cycles after the start edge, div_clk rises with it
    step(0, 0, 0, 1, 0);
    chk("busy_after_start", busy, 1);
    first_tick_latency("default_first_tick", 2501);
    chk("default_div_rise", div_clk, 1);
    idle(3);
    step(0, 0, 0, 0, 1);

    // periodic P=3: five ticks in 20 cycles
    step(1, 3, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    idle(20);
`ifdef TICK_CNT_EN
    chk("p3_tick_cnt", tick_cnt, 5);
`endif
    step(0, 0, 0, 0, 1);

    // one-shot P=5, then relaunch from DONE with the same config
    step(1, 5, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    first_tick_latency("oneshot_first_tick", 6);
    chk("oneshot_done", done, 1);
    idle(3);
    chk("oneshot_ready", cfg_ready, 1);
    step(0, 0, 0, 1, 0);
    chk("restart_done_clear", done, 0);
    first_tick_latency("oneshot_second_tick", 6);
    idle(2);

    // cfg ignored while running; stop on the expiry edge suppresses the tick
    step(1, 4, 0, 1, 0);
    idle(2);
    step(1, 7, 0, 0, 0);
    chk("cfg_ready_in_run", cfg_ready, 0);
    while ((m_el + 1) % (m_p + 1) != 0) step(1, 7, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("stop_no_tick", tick, 0);
    chk("stop_idle", busy, 0);
    step(0, 0, 0, 1, 0);
    first_tick_latency("period_kept_4", 5);
    step(0, 0, 0, 0, 1);

    // period 0 clamps to 1; start with stop stays idle
    step(1, 0, 0, 1, 0);
    idle(9);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    chk("start_stop_idle", busy, 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 6), $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
    step(0, 0, 0, 0, 1);

    // asynchronous reset mid-cycle during a run at count 2
    step(1, 9, 0, 1, 0);
    idle(2);
    #2 reset = 1;
    #1;
    model_reset();
    chk("async_busy", busy, 0);
    chk("async_ready", cfg_ready, 1);
    chk("async_tick", tick, 0);
    chk("async_div", div_clk, 0);
    @(negedge clk);
    reset = 0;
    check_outputs();
    step(0, 0, 0, 1, 0);
    first_tick_latency("post_reset_period", 2501);
    step(0, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
